bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It takes a 10-bit binary value and produces the 12-bit, 3-digit packed BCD word consumed by the seven-segment display decoder (`bcd2display`). A start/busy/done handshake is used, and one bit is processed per clock. Inputs above 999 saturate to 999 and raise an overflow flag, so the display never shows an invalid digit.

## Interface
- Parameters: none. Widths are fixed by package constants: BIN_W = 10, BCD_W = 12, MAX_VAL = 999.
- `clk` — input, 1 — system clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-high reset.
- `start` — input, 1 — request a conversion of `binario`; sampled only in IDLE or DONE.
- `binario` — input, 10 — unsigned binary operand; captured in the cycle `start` is accepted.
- `valor` — output, 12 — packed BCD result: [11:8] hundreds, [7:4] tens, [3:0] units; registered.
- `busy` — output, 1 — high while a conversion is in progress.
- `done` — output, 1 — one-cycle pulse when `valor` has just been updated.
- `overflow` — output, 1 — the last accepted operand was >999; valid from `done` until the next `done`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - If `start`=1: load the operand and go to SHIFT.
  - Loaded operand: `binario` if it is ≤999, else 999.
  - Set the overflow capture bit to (`binario` > 999).
- **SHIFT**, once per cycle:
  - For each of the 3 BCD nibbles of the working register, add 3 if the nibble is ≥5.
  - Then shift the 22-bit register {bcd[11:0], bin[9:0]} left by one.
  - The iteration counter (4 bits) runs 0..9. After iteration 9, copy bcd into `valor` and the capture bit into `overflow`, then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle.
  - If `start`=1 in DONE, it is accepted exactly as in IDLE (back-to-back conversion, straight to SHIFT). Otherwise go to IDLE.
- `start` while in SHIFT is ignored. No queueing; the operand is not re-sampled.
- `valor` and `overflow` change only on the transition into DONE. They hold their value otherwise, including during the next conversion.
- Width rules:
  - Nibble correction is a 4-bit add. A nibble ≤9 before correction never exceeds 12, so no carry.
  - Because operands are clamped to ≤999, the result never needs a 4th digit.

## Timing
- Reset values, applied asynchronously:
  - State IDLE, counter 0, working register 0.
  - `valor`=12'h000, `busy`=0, `done`=0, `overflow`=0.
- Cycle-level sequence, with `start` accepted on the edge ending cycle N:
  - Cycles N+1 … N+10: `busy`=1, SHIFT iterations 0..9.
  - Cycle N+11: `valor` and `overflow` are valid, `done`=1, `busy`=0.
- Latency from `start` to `done` is 11 cycles. Minimum start-to-start spacing is 11 cycles, achieved by asserting `start` during `done`.
- `busy` is a registered state decode: 1 exactly in SHIFT. `done` is 1 exactly in DONE. They are never high together.
- Reset asserted mid-conversion:
  - All of the above return to their reset values immediately.
  - No `done` is produced for the aborted conversion.
  - After deassertion the block waits in IDLE.
- `binario` may change freely after the accepting edge.

## Structure
- Package `bcd_pkg` holds:
  - constants BIN_W, BCD_W, MAX_VAL;
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - ITER_LAST = 9.
- Sub-module `bcd_add3`: 4-bit combinational corrector (output = input+3 if input ≥5, else input). It is instantiated 3 times on the working register.
- The top level contains the FSM, the counter, the 22-bit shift register and the output registers.

## Test plan
- After reset, with no `start`: `valor`=12'h000, `busy`=0, `done`=0, `overflow`=0 for 20 cycles.
- `binario`=0, 123, 999 in sequence, each with a 1-cycle `start` pulse:
  - `done` arrives exactly 11 cycles after each `start`;
  - `valor`=12'h000, 12'h123, 12'h999 respectively, with `overflow`=0;
  - `busy` is high for 10 cycles each time.
- `binario`=1023, then `binario`=1000: `valor`=12'h999 and `overflow`=1 for both. A following conversion of 5 gives `valor`=12'h005 and clears `overflow`.
- Start 45, then pulse `start` with `binario`=678 while `busy`: the second start is ignored, and exactly one `done` arrives with `valor`=12'h045.
- Back-to-back conversions, with `start` held during `done`:
  - 250 → `valor`=12'h250;
  - 7 → `valor`=12'h007;
  - `done` pulses are 11 cycles apart.
- Assert `reset` 5 cycles into a conversion of 888: outputs clear immediately and no `done` appears. A conversion of 31 after release gives `valor`=12'h031. An exhaustive sweep of 0..1023 is checked against a reference model.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Widths, clamp value, iteration bound and FSM state encoding.
`timescale 1ns/1ps
package bcd_pkg;

  localparam int BIN_W  = 10;
  localparam int BCD_W  = 12;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = 4;

  localparam logic [BIN_W-1:0] MAX_VAL   = 10'd999;
  localparam logic [CNT_W-1:0] ITER_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Saturate an operand so the result always fits in three digits.
  function automatic logic [BIN_W-1:0] clamp(
    input logic [BIN_W-1:0] v
  );
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble corrector.
// Adds 3 to a nibble of 5 or more so the next shift carries into the next digit.
`timescale 1ns/1ps
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs are at most 9, so the 4-bit sum never wraps.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter, one bit per clock.
// Operands above 999 are clamped to 999 and flagged through overflow.
`timescale 1ns/1ps
module bin2bcd_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] binario,
  output logic [BCD_W-1:0] valor,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   shifted;
  logic [BCD_W-1:0]    fix;
  logic                ovf_cap;
  logic                accept;
  logic                last;

  // One corrector per BCD digit of the working register.
  for (genvar i = 0; i < 3; i++) begin : g_fix
    bcd_add3 u_add3 (
      .din  (work[BIN_W+4*i +: 4]),
      .dout (fix[4*i +: 4])
    );
  end

  // The top digit's carry-out is always zero for clamped operands.
  assign shifted = {fix, work[BIN_W-1:0]} << 1;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) && (cnt == ITER_LAST);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DONE accepts a new start like IDLE does.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working register, iteration counter and overflow capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work    <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
    end else if (accept) begin
      work    <= {{BCD_W{1'b0}}, clamp(binario)};
      cnt     <= '0;
      ovf_cap <= (binario > MAX_VAL);
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= last ? '0 : cnt + 4'd1;
    end
  end

  // Results update only on the final shift, holding through later runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valor    <= '0;
      overflow <= 1'b0;
    end else if (last) begin
      valor    <= shifted[WORK_W-1:BIN_W];
      overflow <= ovf_cap;
    end
  end

endmodule
